// File: rtl/instr_encoder.sv
// instr_encoder: turns operation/field requests into 32-bit MIPS instruction
// words, tags each with a sequential word address and queues them in a small
// output FIFO with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear of FIFO and address counter
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target
//                  request side
//   out_valid/out_ready, out_instr, out_addr
//                  FIFO head (registered)
//   err_illegal    one-cycle pulse after an illegal op is accepted
//   illegal_cnt    saturating count of accepted illegal ops
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] K_ILL = 2'd0;
  localparam logic [1:0] K_R   = 2'd1;
  localparam logic [1:0] K_I   = 2'd2;
  localparam logic [1:0] K_J   = 2'd3;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      addr_mem  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      addr_cnt;

  logic [1:0]  kind;
  logic [5:0]  code;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [31:0] enc;
  logic        accept, illegal, push, pop;
  logic [31:0] head_instr_nxt, head_addr_nxt;

  // Opcode / funct lookup and field forcing
  always_comb begin
    kind = K_ILL;
    code = 6'd0;
    case (in_op)
      5'd0:  begin kind = K_R; code = 6'b100000; end // add
      5'd1:  begin kind = K_R; code = 6'b100001; end // addu
      5'd2:  begin kind = K_R; code = 6'b100100; end // and
      5'd3:  begin kind = K_R; code = 6'b001000; end // jr
      5'd4:  begin kind = K_R; code = 6'b100111; end // nor
      5'd5:  begin kind = K_R; code = 6'b100101; end // or
      5'd6:  begin kind = K_R; code = 6'b101010; end // slt
      5'd7:  begin kind = K_R; code = 6'b101011; end // sltu
      5'd8:  begin kind = K_R; code = 6'b000000; end // sll
      5'd9:  begin kind = K_R; code = 6'b000010; end // srl
      5'd10: begin kind = K_R; code = 6'b100010; end // sub
      5'd11: begin kind = K_R; code = 6'b100011; end // subu
      5'd12: begin kind = K_R; code = 6'b000011; end // sra
      5'd13: begin kind = K_J; code = 6'b000010; end // j
      5'd14: begin kind = K_J; code = 6'b000011; end // jal
      5'd15: begin kind = K_I; code = 6'b001000; end // addi
      5'd16: begin kind = K_I; code = 6'b001001; end // addiu
      5'd17: begin kind = K_I; code = 6'b001100; end // andi
      5'd18: begin kind = K_I; code = 6'b000100; end // beq
      5'd19: begin kind = K_I; code = 6'b000101; end // bne
      5'd20: begin kind = K_I; code = 6'b110000; end // ll
      5'd21: begin kind = K_I; code = 6'b001111; end // lui
      5'd22: begin kind = K_I; code = 6'b100011; end // lw
      5'd23: begin kind = K_I; code = 6'b001101; end // ori
      5'd24: begin kind = K_I; code = 6'b001010; end // slti
      5'd25: begin kind = K_I; code = 6'b001011; end // sltiu
      5'd26: begin kind = K_I; code = 6'b101011; end // sw
      default: begin kind = K_ILL; code = 6'd0; end
    endcase

    rs_f = in_rs;
    rt_f = in_rt;
    rd_f = in_rd;
    sh_f = 5'd0;
    // Shifts take shamt and ignore rs
    if (in_op == 5'd8 || in_op == 5'd9 || in_op == 5'd12) begin
      rs_f = 5'd0;
      sh_f = in_shamt;
    end
    if (in_op == 5'd3) begin
      rt_f = 5'd0;
      rd_f = 5'd0;
    end
    if (in_op == 5'd21) rs_f = 5'd0;

    case (kind)
      K_R:     enc = {6'b000000, rs_f, rt_f, rd_f, sh_f, code};
      K_I:     enc = {code, rs_f, rt_f, in_imm};
      K_J:     enc = {code, in_target};
      default: enc = 32'd0;
    endcase
  end

  assign illegal  = (kind == K_ILL);
  assign in_ready = rst_n && !flush && (count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && !illegal;
  assign pop      = out_valid && out_ready;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  // Next head: the word being pushed when the queue drains to it, else storage
  always_comb begin
    head_instr_nxt = instr_mem[rd_ptr_nxt];
    head_addr_nxt  = addr_mem[rd_ptr_nxt];
    if (count == CNT_W'(0) || (count == CNT_W'(1) && pop)) begin
      head_instr_nxt = enc;
      head_addr_nxt  = addr_cnt;
    end
  end

  // FIFO storage (contents are only read once written, so no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc;
      addr_mem[wr_ptr]  <= addr_cnt;
    end
  end

  // Pointers, occupancy, address counter and registered head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      addr_cnt    <= BASE_ADDR;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_addr    <= 32'd0;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      addr_cnt    <= BASE_ADDR;
      out_valid   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != CNT_W'(0));
      if (count_nxt != CNT_W'(0)) begin
        out_instr <= head_instr_nxt;
        out_addr  <= head_addr_nxt;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        addr_cnt <= addr_cnt + 32'd4;
      end
      err_illegal <= accept && illegal;
      if (accept && illegal && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (DEPTH=4, BASE_ADDR=0).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'd0 || out_addr !== 32'd0) begin n_err++;
      $display("FAIL reset_out_data got %h/%h want 0/0", out_instr, out_addr); end
    n_cmp++; if (err_illegal !== 1'b0 || illegal_cnt !== 8'd0) begin n_err++;
      $display("FAIL reset_illegal got %b/%0d want 0/0", err_illegal, illegal_cnt); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_rtype_latency();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'd0, 26'd0);
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_no_early_valid got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820 || out_addr !== 32'd0) begin n_err++;
      $display("FAIL add_word got v=%b %h @%h want v=1 00221820 @0", out_valid, out_instr, out_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'h0022_1820) begin n_err++;
      $display("FAIL add_hold_empty got v=%b %h want v=0 00221820", out_valid, out_instr); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h2008_FFFF; exp_w[1] = 32'h3C09_1234; exp_w[2] = 32'h0800_0100;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_req(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'd0); tick();
    set_req(5'd21, 5'd5, 5'd9, 5'd0, 5'd0, 16'h1234, 26'd0); tick();
    set_req(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000100); tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== exp_w[i] || out_addr !== 32'(4 * i)) begin n_err++;
        $display("FAIL seq_%0d got v=%b %h @%h want v=1 %h @%h", i, out_valid, out_instr, out_addr, exp_w[i], 32'(4 * i)); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL seq_drained got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    logic exp_rdy;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      set_req(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 16'(i), 26'd0);
      in_valid = 1'b1;
      #1;
      exp_rdy = (i < 4);
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++;
        $display("FAIL full_in_ready_%0d got %b want %b", i, in_ready, exp_rdy); end
      tick();
    end
    n_cmp++; if (out_instr !== 32'h2008_0000 || out_addr !== 32'd0) begin n_err++;
      $display("FAIL full_head_held got %h @%h want 20080000 @0", out_instr, out_addr); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_with_pop got %b want 0", in_ready); end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== (32'h2008_0000 | 32'(i)) || out_addr !== 32'(4 * i)) begin n_err++;
        $display("FAIL full_drain_%0d got v=%b %h @%h want v=1 %h @%h", i, out_valid, out_instr, out_addr,
                 32'h2008_0000 | 32'(i), 32'(4 * i)); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained got %b want 0", out_valid); end
  endtask

  // Streaming push+pop every cycle, also covering field forcing and other formats
  task automatic test_back_to_back();
    logic [4:0]  ops  [8];
    logic [4:0]  rs   [8];
    logic [4:0]  rt   [8];
    logic [4:0]  rd   [8];
    logic [4:0]  sh   [8];
    logic [15:0] imm  [8];
    logic [25:0] tgt  [8];
    logic [31:0] expw [8];
    ops[0]=5'd8;  rs[0]=5'd7;  rt[0]=5'd2;  rd[0]=5'd4; sh[0]=5'd3;  imm[0]=16'd0;     tgt[0]=26'd0;         expw[0]=32'h0002_20C0;
    ops[1]=5'd3;  rs[1]=5'd31; rt[1]=5'd5;  rd[1]=5'd6; sh[1]=5'd7;  imm[1]=16'd0;     tgt[1]=26'd0;         expw[1]=32'h03E0_0008;
    ops[2]=5'd12; rs[2]=5'd1;  rt[2]=5'd3;  rd[2]=5'd2; sh[2]=5'd31; imm[2]=16'd0;     tgt[2]=26'd0;         expw[2]=32'h0003_17C3;
    ops[3]=5'd4;  rs[3]=5'd1;  rt[3]=5'd2;  rd[3]=5'd3; sh[3]=5'd9;  imm[3]=16'd0;     tgt[3]=26'd0;         expw[3]=32'h0022_1827;
    ops[4]=5'd26; rs[4]=5'd29; rt[4]=5'd31; rd[4]=5'd7; sh[4]=5'd1;  imm[4]=16'h8000;  tgt[4]=26'd0;         expw[4]=32'hAFBF_8000;
    ops[5]=5'd14; rs[5]=5'd3;  rt[5]=5'd3;  rd[5]=5'd3; sh[5]=5'd3;  imm[5]=16'h1111;  tgt[5]=26'h3FF_FFFF; expw[5]=32'h0FFF_FFFF;
    ops[6]=5'd18; rs[6]=5'd1;  rt[6]=5'd2;  rd[6]=5'd0; sh[6]=5'd0;  imm[6]=16'hFFFC;  tgt[6]=26'd0;         expw[6]=32'h1022_FFFC;
    ops[7]=5'd20; rs[7]=5'd4;  rt[7]=5'd5;  rd[7]=5'd0; sh[7]=5'd0;  imm[7]=16'h0010;  tgt[7]=26'd0;         expw[7]=32'hC085_0010;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(ops[i], rs[i], rt[i], rd[i], sh[i], imm[i], tgt[i]);
      in_valid = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== expw[i] || out_addr !== 32'(4 * i)) begin n_err++;
        $display("FAIL b2b_%0d got v=%b %h @%h want v=1 %h @%h", i, out_valid, out_instr, out_addr, expw[i], 32'(4 * i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd30, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'd0);
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (err_illegal !== 1'b1 || illegal_cnt !== 8'd1 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL ill_pulse got err=%b cnt=%0d v=%b want 1/1/0", err_illegal, illegal_cnt, out_valid); end
    tick();
    n_cmp++; if (err_illegal !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL ill_pulse_end got err=%b v=%b want 0/0", err_illegal, out_valid); end
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'd0) begin n_err++;
      $display("FAIL ill_addr_kept got v=%b @%h want v=1 @0", out_valid, out_addr); end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_req(5'(27 + (i % 5)), 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (illegal_cnt !== 8'd255) begin n_err++; $display("FAIL ill_saturate got %0d want 255", illegal_cnt); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    set_req(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_req(5'd16, 5'd2, 5'd3, 5'd0, 5'd0, 16'(i + 1), 26'd0);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'd0) begin n_err++;
      $display("FAIL flush_pre got v=%b @%h want v=1 @0", out_valid, out_addr); end
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || illegal_cnt !== 8'd1) begin n_err++;
      $display("FAIL flush_empty got v=%b cnt=%0d want v=0 cnt=1", out_valid, illegal_cnt); end
    set_req(5'd23, 5'd1, 5'd1, 5'd0, 5'd0, 16'h00FF, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h3421_00FF || out_addr !== 32'd0) begin n_err++;
      $display("FAIL flush_next_push got v=%b %h @%h want v=1 342100FF @0", out_valid, out_instr, out_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    set_req(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== 32'd0 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL async_rst got v=%b %h @%h rdy=%b want 0/0/0/0", out_valid, out_instr, out_addr, in_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    out_ready = 1'b1;
    set_req(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h3022_ABCD || out_addr !== 32'd0) begin n_err++;
      $display("FAIL async_rst_push got v=%b %h @%h want v=1 3022ABCD @0", out_valid, out_instr, out_addr); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    test_reset();
    test_rtype_latency();
    test_sequence();
    test_full();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: word address given to the first emitted instruction.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  synchronous clear of FIFO and address counter.
REQ-006 in_valid  in  1  request holds a valid instruction description.
REQ-007 in_ready  out  1  encoder accepts the request this cycle.
REQ-008 in_op  in  5  operation select, coded per REQ-015.
REQ-009 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-010 in_imm  in  16  I-type immediate.
REQ-011 in_target  in  26  J-type target.
REQ-012 out_valid  out  1  out_instr and out_addr are valid.
REQ-013 out_ready  in  1  sink consumes the head entry.
REQ-014 out_instr  out  32  encoded MIPS word; out_addr  out  32  its byte address; err_illegal  out  1  one-cycle pulse; illegal_cnt  out  8  saturating count of illegal requests.

Function
REQ-015 in_op codes: 0 add, 1 addu, 2 and, 3 jr, 4 nor, 5 or, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sub, 11 subu, 12 sra, 13 j, 14 jal, 15 addi, 16 addiu, 17 andi, 18 beq, 19 bne, 20 ll, 21 lui, 22 lw, 23 ori, 24 slti, 25 sltiu, 26 sw; 27-31 illegal.
REQ-016 R-type word = {6'b000000, rs, rt, rd, shamt, funct}; funct: add 100000, addu 100001, and 100100, jr 001000, nor 100111, or 100101, slt 101010, sltu 101011, sll 000000, srl 000010, sub 100010, subu 100011, sra 000011.
REQ-017 Field forcing: shamt=0 for non-shift R-type; rs=0 for sll/srl/sra; rt=rd=shamt=0 for jr; rs=0 for lui.
REQ-018 I-type word = {opcode, rs, rt, imm}; opcodes: addi 001000, addiu 001001, andi 001100, beq 000100, bne 000101, ll 110000, lui 001111, lw 100011, ori 001101, slti 001010, sltiu 001011, sw 101011.
REQ-019 J-type word = {opcode, target}; j 000010, jal 000011.
REQ-020 Handshake: transfer when in_valid && in_ready; in_ready = !flush && (FIFO occupancy < DEPTH).
REQ-021 Accepted legal request is encoded and pushed in the same edge; it appears at FIFO head (out_valid=1) no earlier than the next cycle; no combinational path from in_* to out_*.
REQ-022 FIFO pops when out_valid && out_ready; out_instr/out_addr stable while out_valid && !out_ready.
REQ-023 Simultaneous push and pop when not full: occupancy unchanged, order preserved; when full, in_ready=0 regardless of out_ready in that cycle.
REQ-024 out_addr of each pushed entry = address counter value at push; counter starts at BASE_ADDR, increments by 4 per legal push, wraps modulo 2^32.
REQ-025 Accepted illegal request (op 27-31): consumes handshake, not pushed, address counter unchanged, err_illegal=1 the following cycle for exactly one cycle, illegal_cnt +1 saturating at 255.
REQ-026 flush=1: next edge empties FIFO, address counter = BASE_ADDR, no push that cycle; illegal_cnt retained.
REQ-027 Empty FIFO: out_valid=0, out_instr and out_addr hold last values (zero after reset).

Reset
REQ-028 rst_n=0 asynchronously sets: FIFO empty, out_valid=0, out_instr=0, out_addr=0, counter=BASE_ADDR, err_illegal=0, illegal_cnt=0; in_ready=0 while rst_n=0.
REQ-029 Reset mid-transfer discards all queued entries; first post-reset push gets out_addr=BASE_ADDR.

Verification
REQ-030 add rs=1 rt=2 rd=3 shamt=7, out_ready=1 -> next cycle out_instr=32'h0022_1820, out_addr=0.
REQ-031 Sequence addi rs=0 rt=8 imm=16'hFFFF; lui rs=5 rt=9 imm=16'h1234; j target=26'h0000100 -> 32'h2008_FFFF @0, 32'h3C09_1234 @4, 32'h0800_0100 @8.
REQ-032 out_ready=0, push DEPTH+1 requests -> in_ready drops after DEPTH accepts; out_instr held; release out_ready -> all DEPTH words emerge in order.
REQ-033 in_op=30 -> err_illegal one-cycle pulse, illegal_cnt=1, no out_valid, next legal push out_addr unchanged; 300 illegal ops -> illegal_cnt=255.
REQ-034 Three entries queued, assert flush one cycle -> out_valid=0 next cycle, next push out_addr=BASE_ADDR; assert rst_n=0 asynchronously mid-stream -> all outputs zero immediately.
